// File: rtl/dma_req_arbiter.sv
// dma_req_arbiter: round-robin arbiter sharing one DMA request channel among
// N_REQ requesters. Each grant issues a DMA request plus a datapath-mux
// descriptor, and records the granted vfid in an in-order completion queue
// so that DMA done pulses are routed back to the originating requester.
// Optional build macro DMA_ARB_PRIO_EN: requester 0 gets strict priority and
// requesters 1..N_REQ-1 round-robin among themselves.
module dma_req_arbiter #(
  parameter int N_REQ         = 4,
  parameter int N_ID_BITS     = 2,
  parameter int ADDR_BITS     = 64,
  parameter int LEN_BITS      = 28,
  parameter int ARB_DATA_BITS = 512,
  parameter int N_OUTSTANDING = 8
) (
  input  logic                                    aclk,
  input  logic                                    aresetn,
  input  logic [N_REQ-1:0]                        s_req_valid,
  output logic [N_REQ-1:0]                        s_req_ready,
  input  logic [N_REQ*ADDR_BITS-1:0]              s_req_addr,
  input  logic [N_REQ*LEN_BITS-1:0]               s_req_len,
  input  logic [N_REQ-1:0]                        s_req_last,
  output logic [N_REQ-1:0]                        s_rsp_done,
  output logic                                    m_req_valid,
  input  logic                                    m_req_ready,
  output logic [ADDR_BITS-1:0]                    m_req_addr,
  output logic [LEN_BITS-1:0]                     m_req_len,
  output logic                                    m_req_last,
  input  logic                                    m_rsp_done,
  output logic                                    mux_valid,
  input  logic                                    mux_ready,
  output logic [N_ID_BITS-1:0]                    mux_vfid,
  output logic [LEN_BITS-$clog2(ARB_DATA_BITS/8)-1:0] mux_len,
  output logic                                    mux_ctl,
  output logic [$clog2(N_OUTSTANDING):0]          outstanding,
  output logic                                    cpl_err
);

  localparam int BEAT_LOG_BITS = $clog2(ARB_DATA_BITS / 8);
  localparam int MUX_LEN_BITS  = LEN_BITS - BEAT_LOG_BITS;
  localparam int QPTR_BITS     = $clog2(N_OUTSTANDING);
  localparam int CNT_BITS      = QPTR_BITS + 1;

  localparam logic [N_REQ-1:0]     REQ_ONE    = {{(N_REQ-1){1'b0}}, 1'b1};
  localparam logic [N_ID_BITS-1:0] ID_ZERO    = {N_ID_BITS{1'b0}};
  localparam logic [N_ID_BITS-1:0] ID_ONE     = {{(N_ID_BITS-1){1'b0}}, 1'b1};
  localparam logic [N_ID_BITS-1:0] ID_LAST    = N_ID_BITS'(N_REQ - 1);
  localparam logic [QPTR_BITS-1:0] PTR_ONE    = {{(QPTR_BITS-1){1'b0}}, 1'b1};
  localparam logic [CNT_BITS-1:0]  CNT_ZERO   = {CNT_BITS{1'b0}};
  localparam logic [CNT_BITS-1:0]  CNT_ONE    = {{(CNT_BITS-1){1'b0}}, 1'b1};
  localparam logic [CNT_BITS-1:0]  CNT_FULL   = CNT_BITS'(N_OUTSTANDING);
  localparam logic [LEN_BITS:0]    LEN_ONE    = {{LEN_BITS{1'b0}}, 1'b1};
  localparam logic [LEN_BITS:0]    BEAT_ROUND = (LEN_BITS + 1)'((2 ** BEAT_LOG_BITS) - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_t;

  state_t                  state_r, state_nxt_s;
  logic [N_ID_BITS-1:0]    rr_ptr_r;
  logic [N_ID_BITS-1:0]    grant_idx_s;
  logic                    grant_any_s;
  logic                    grant_s;
  int                      best_dist_s;
  logic                    m_done_s, mux_done_s;
  logic                    m_req_valid_r, mux_valid_r, m_req_last_r, mux_ctl_r;
  logic [ADDR_BITS-1:0]    m_req_addr_r;
  logic [LEN_BITS-1:0]     m_req_len_r, len_sel_s;
  logic [LEN_BITS:0]       beats_s;
  logic [MUX_LEN_BITS-1:0] mux_len_s, mux_len_r;
  logic [N_ID_BITS-1:0]    mux_vfid_r;
  logic [N_ID_BITS-1:0]    cq_mem_r [N_OUTSTANDING];
  logic [QPTR_BITS-1:0]    wr_ptr_r, rd_ptr_r;
  logic [CNT_BITS-1:0]     count_r;
  logic                    q_full_s, q_empty_s, push_s, pop_s;
  logic [N_REQ-1:0]        s_rsp_done_r;
  logic                    cpl_err_r;

  assign q_full_s  = (count_r == CNT_FULL);
  assign q_empty_s = (count_r == CNT_ZERO);
  assign grant_s   = (state_r == ST_IDLE) && grant_any_s && !q_full_s;
  assign push_s    = grant_s;
  assign pop_s     = m_rsp_done && !q_empty_s;
  assign m_done_s  = !m_req_valid_r || m_req_ready;
  assign mux_done_s = !mux_valid_r || mux_ready;

  // Pick the valid requester closest at-or-after the round-robin pointer.
  always_comb begin
    grant_any_s = 1'b0;
    grant_idx_s = ID_ZERO;
    best_dist_s = N_REQ;
    for (int i = 0; i < N_REQ; i++) begin
      if (s_req_valid[i] && (((i + N_REQ - int'(rr_ptr_r)) % N_REQ) < best_dist_s)) begin
        best_dist_s = (i + N_REQ - int'(rr_ptr_r)) % N_REQ;
        grant_idx_s = N_ID_BITS'(i);
        grant_any_s = 1'b1;
      end else begin
        best_dist_s = best_dist_s;
      end
    end
`ifdef DMA_ARB_PRIO_EN
    if (s_req_valid[0]) begin
      grant_idx_s = ID_ZERO;
    end else begin
      grant_idx_s = grant_idx_s;
    end
`endif
  end

  // Accept strobe is combinational in ST_IDLE and forced low while in reset.
  always_comb begin
    if (grant_s && aresetn) begin
      s_req_ready = REQ_ONE << grant_idx_s;
    end else begin
      s_req_ready = {N_REQ{1'b0}};
    end
  end

  // Beat count minus one for the mux; zero length saturates to zero.
  always_comb begin
    len_sel_s = s_req_len[int'(grant_idx_s)*LEN_BITS +: LEN_BITS];
    beats_s   = ({1'b0, len_sel_s} + BEAT_ROUND) >> BEAT_LOG_BITS;
    if (len_sel_s == {LEN_BITS{1'b0}}) begin
      mux_len_s = {MUX_LEN_BITS{1'b0}};
    end else begin
      mux_len_s = MUX_LEN_BITS'(beats_s - LEN_ONE);
    end
  end

  // FSM state register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state_r <= ST_IDLE;
    else          state_r <= state_nxt_s;
  end

  // FSM next state: leave ST_ISSUE once both handshakes have completed.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (grant_s) state_nxt_s = ST_ISSUE;
        else         state_nxt_s = ST_IDLE;
      end
      ST_ISSUE: begin
        if (m_done_s && mux_done_s) state_nxt_s = ST_IDLE;
        else                        state_nxt_s = ST_ISSUE;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Round-robin pointer advances past the winner (priority grants leave it).
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rr_ptr_r <= ID_ZERO;
    end else if (grant_s) begin
`ifdef DMA_ARB_PRIO_EN
      if (grant_idx_s == ID_ZERO)     rr_ptr_r <= rr_ptr_r;
      else if (grant_idx_s == ID_LAST) rr_ptr_r <= ID_ZERO;
      else                             rr_ptr_r <= grant_idx_s + ID_ONE;
`else
      if (grant_idx_s == ID_LAST) rr_ptr_r <= ID_ZERO;
      else                        rr_ptr_r <= grant_idx_s + ID_ONE;
`endif
    end
  end

  // Request/descriptor registers: load on grant, drop each valid on its handshake.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_req_valid_r <= 1'b0;
      mux_valid_r   <= 1'b0;
      m_req_addr_r  <= {ADDR_BITS{1'b0}};
      m_req_len_r   <= {LEN_BITS{1'b0}};
      m_req_last_r  <= 1'b0;
      mux_vfid_r    <= ID_ZERO;
      mux_len_r     <= {MUX_LEN_BITS{1'b0}};
      mux_ctl_r     <= 1'b0;
    end else if (grant_s) begin
      m_req_valid_r <= 1'b1;
      mux_valid_r   <= 1'b1;
      m_req_addr_r  <= s_req_addr[int'(grant_idx_s)*ADDR_BITS +: ADDR_BITS];
      m_req_len_r   <= len_sel_s;
      m_req_last_r  <= s_req_last[grant_idx_s];
      mux_vfid_r    <= grant_idx_s;
      mux_len_r     <= mux_len_s;
      mux_ctl_r     <= s_req_last[grant_idx_s];
    end else begin
      if (m_req_valid_r && m_req_ready) m_req_valid_r <= 1'b0;
      if (mux_valid_r && mux_ready)     mux_valid_r   <= 1'b0;
    end
  end

  // Completion queue: vfid FIFO, occupancy, done routing and sticky error.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < N_OUTSTANDING; i++) cq_mem_r[i] <= ID_ZERO;
      wr_ptr_r     <= {QPTR_BITS{1'b0}};
      rd_ptr_r     <= {QPTR_BITS{1'b0}};
      count_r      <= CNT_ZERO;
      s_rsp_done_r <= {N_REQ{1'b0}};
      cpl_err_r    <= 1'b0;
    end else begin
      if (push_s) begin
        cq_mem_r[wr_ptr_r] <= grant_idx_s;
        wr_ptr_r           <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r     <= rd_ptr_r + PTR_ONE;
        s_rsp_done_r <= REQ_ONE << cq_mem_r[rd_ptr_r];
      end else begin
        s_rsp_done_r <= {N_REQ{1'b0}};
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
      if (m_rsp_done && q_empty_s) cpl_err_r <= 1'b1;
    end
  end

  assign m_req_valid = m_req_valid_r;
  assign m_req_addr  = m_req_addr_r;
  assign m_req_len   = m_req_len_r;
  assign m_req_last  = m_req_last_r;
  assign mux_valid   = mux_valid_r;
  assign mux_vfid    = mux_vfid_r;
  assign mux_len     = mux_len_r;
  assign mux_ctl     = mux_ctl_r;
  assign outstanding = count_r;
  assign s_rsp_done  = s_rsp_done_r;
  assign cpl_err     = cpl_err_r;

endmodule

// File: tb/tb_dma_req_arbiter.sv
// Self-checking bench for dma_req_arbiter: directed scenarios plus randomized
// traffic, all compared every cycle against a transaction-level model.
module tb_dma_req_arbiter;

  localparam int NR = 4;
  localparam int AB = 64;
  localparam int LB = 28;
  localparam int NO = 8;
  localparam int BEAT_BYTES = 64;

  logic            aclk = 1'b0;
  logic            aresetn;
  logic [NR-1:0]   req_valid, s_req_ready, req_last, s_rsp_done;
  logic [NR*AB-1:0] req_addr;
  logic [NR*LB-1:0] req_len;
  logic            m_req_valid, m_req_ready, m_req_last, m_rsp_done;
  logic [AB-1:0]   m_req_addr;
  logic [LB-1:0]   m_req_len;
  logic            mux_valid, mux_ready, mux_ctl;
  logic [1:0]      mux_vfid;
  logic [21:0]     mux_len;
  logic [3:0]      outstanding;
  logic            cpl_err;

  always #5 aclk = ~aclk;

  dma_req_arbiter dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_req_valid(req_valid), .s_req_ready(s_req_ready),
    .s_req_addr(req_addr), .s_req_len(req_len), .s_req_last(req_last),
    .s_rsp_done(s_rsp_done),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready),
    .m_req_addr(m_req_addr), .m_req_len(m_req_len), .m_req_last(m_req_last),
    .m_rsp_done(m_rsp_done),
    .mux_valid(mux_valid), .mux_ready(mux_ready), .mux_vfid(mux_vfid),
    .mux_len(mux_len), .mux_ctl(mux_ctl),
    .outstanding(outstanding), .cpl_err(cpl_err)
  );

  int checks = 0;
  int failures = 0;

  // Transaction-level model state
  bit          busy, m_pend, x_pend;
  logic [63:0] e_addr;
  longint      e_len, e_mlen;
  bit          e_last, e_err;
  int          e_vfid, rr;
  int          cq[$];
  logic [3:0]  e_done;

  int          g_last;
  logic [3:0]  rdy_seen;
  int          got[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint beats_m1(input longint len);
    if (len == 0) return 0;
    return (len + BEAT_BYTES - 1) / BEAT_BYTES - 1;
  endfunction

  function automatic int model_grant(input logic [3:0] v);
    if (busy || v == 4'b0000 || cq.size() >= NO) return -1;
`ifdef DMA_ARB_PRIO_EN
    if (v[0]) return 0;
`endif
    for (int k = 0; k < NR; k++)
      if (v[(rr + k) % NR]) return (rr + k) % NR;
    return -1;
  endfunction

  task automatic model_reset();
    busy = 0; m_pend = 0; x_pend = 0; e_addr = 64'd0; e_len = 0; e_mlen = 0;
    e_last = 0; e_err = 0; e_vfid = 0; rr = 0; cq.delete(); e_done = 4'b0000;
  endtask

  task automatic cmp_outputs(input logic [3:0] er);
    chk("s_req_ready", s_req_ready, er);
    chk("m_req_valid", m_req_valid, m_pend);
    chk("mux_valid", mux_valid, x_pend);
    chk("m_req_addr", m_req_addr, e_addr);
    chk("m_req_len", m_req_len, e_len);
    chk("m_req_last", m_req_last, e_last);
    chk("mux_vfid", mux_vfid, e_vfid);
    chk("mux_len", mux_len, e_mlen);
    chk("mux_ctl", mux_ctl, e_last);
    chk("outstanding", outstanding, cq.size());
    chk("s_rsp_done", s_rsp_done, e_done);
    chk("cpl_err", cpl_err, e_err);
  endtask

  // One clock: compare after inputs settle, then advance the model at the edge.
  task automatic step();
    int g;
    logic [3:0] er;
    bit mr, xr, dn;
    #1;
    g = model_grant(req_valid);
    er = (g >= 0) ? 4'(1 << g) : 4'b0000;
    rdy_seen = s_req_ready;
    g_last = g;
    cmp_outputs(er);
    mr = m_req_ready; xr = mux_ready; dn = m_rsp_done;
    @(posedge aclk);
    e_done = 4'b0000;
    if (dn) begin
      if (cq.size() > 0) begin
        int h;
        h = cq.pop_front();
        e_done[h] = 1'b1;
      end else begin
        e_err = 1;
      end
    end
    if (busy) begin
      if (m_pend && mr) m_pend = 0;
      if (x_pend && xr) x_pend = 0;
      if (!m_pend && !x_pend) busy = 0;
    end else if (g >= 0) begin
      busy = 1; m_pend = 1; x_pend = 1;
      e_addr = req_addr[g*AB +: AB];
      e_len  = req_len[g*LB +: LB];
      e_last = req_last[g];
      e_vfid = g;
      e_mlen = beats_m1(e_len);
      cq.push_back(g);
`ifdef DMA_ARB_PRIO_EN
      if (g != 0) rr = (g + 1) % NR;
`else
      rr = (g + 1) % NR;
`endif
    end
    @(negedge aclk);
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    #1;
    model_reset();
    cmp_outputs(4'b0000);
    chk("rst_m_valid", m_req_valid, 1'b0);
    chk("rst_outstanding", outstanding, 4'd0);
    chk("rst_cpl_err", cpl_err, 1'b0);
    chk("rst_ready", s_req_ready, 4'b0000);
    @(posedge aclk);
    @(posedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
  endtask

  task automatic new_req(input int i);
    req_addr[i*AB +: AB] = {$urandom, $urandom};
    case ($urandom_range(6, 0))
      0: req_len[i*LB +: LB] = 28'd0;
      1: req_len[i*LB +: LB] = 28'd1;
      2: req_len[i*LB +: LB] = 28'd64;
      3: req_len[i*LB +: LB] = 28'd65;
      4: req_len[i*LB +: LB] = 28'hFFFFFFF;
      default: req_len[i*LB +: LB] = 28'($urandom_range(100000, 0));
    endcase
    req_last[i] = 1'($urandom_range(1, 0));
  endtask

  task automatic collect(input int n);
    got.delete();
    for (int c = 0; c < 64 && got.size() < n; c++) begin
      step();
      if (g_last >= 0) got.push_back(g_last);
    end
  endtask

  task automatic settle_idle();
    for (int c = 0; c < 32 && busy; c++) step();
  endtask

  task automatic drain();
    for (int c = 0; c < 32 && cq.size() > 0; c++) begin
      m_rsp_done = 1'b1;
      step();
    end
    m_rsp_done = 1'b0;
  endtask

  initial begin
    int exp_fair[8];
    int exp_rot[4];
    aresetn = 1'b0; req_valid = 4'b0000; req_addr = '0; req_len = '0; req_last = 4'b0000;
    m_req_ready = 1'b0; mux_ready = 1'b0; m_rsp_done = 1'b0;
    model_reset();
    @(negedge aclk);
    #1;
    cmp_outputs(4'b0000);
    @(negedge aclk);
    aresetn = 1'b1;

    // Single request from requester 2, len 200
    m_req_ready = 1'b1; mux_ready = 1'b1;
    req_valid = 4'b0100; req_len[2*LB +: LB] = 28'd200;
    req_addr[2*AB +: AB] = 64'h1234_5678_9abc_def0; req_last[2] = 1'b1;
    step();
    chk("single_ready", rdy_seen, 4'b0100);
    req_valid = 4'b0000;
    chk("single_m_valid", m_req_valid, 1'b1);
    chk("single_len", m_req_len, 28'd200);
    chk("single_vfid", mux_vfid, 2'd2);
    chk("single_mux_len", mux_len, 22'd3);
    step(); step();
    m_rsp_done = 1'b1; step(); m_rsp_done = 1'b0;
    chk("single_done", s_rsp_done, 4'b0100);
    step();
    chk("single_done_once", s_rsp_done, 4'b0000);

    // Fairness and queue full
    do_reset();
    for (int i = 0; i < NR; i++) new_req(i);
    req_valid = 4'b1111;
`ifdef DMA_ARB_PRIO_EN
    exp_fair = '{0, 0, 0, 0, 0, 0, 0, 0};
`else
    exp_fair = '{0, 1, 2, 3, 0, 1, 2, 3};
`endif
    collect(8);
    for (int i = 0; i < 8; i++)
      chk("fair_order", (i < got.size()) ? got[i] : -1, exp_fair[i]);
    step(); step(); step();
    chk("full_ready", rdy_seen, 4'b0000);
    chk("full_outstanding", outstanding, 4'd8);
    m_rsp_done = 1'b1; step(); m_rsp_done = 1'b0;
    chk("pop_outstanding", outstanding, 4'd7);
    step();
    chk("refill_grant", g_last, 0);
    chk("refill_ready", rdy_seen, 4'b0001);
    req_valid = 4'b0000;
    settle_idle();
    drain();
    req_valid = 4'b1110;
    exp_rot = '{1, 2, 3, 1};
    collect(4);
    for (int i = 0; i < 4; i++)
      chk("rot_order", (i < got.size()) ? got[i] : -1, exp_rot[i]);
    settle_idle();

    // Split handshakes: mux stalls 5 cycles
    req_valid = 4'b0010; mux_ready = 1'b0;
    step();
    chk("split_grant", g_last, 1);
    step();
    chk("split_m_drop", m_req_valid, 1'b0);
    chk("split_x_hold", mux_valid, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("split_no_grant", rdy_seen, 4'b0000);
      chk("split_vfid", mux_vfid, 2'd1);
    end
    mux_ready = 1'b1;
    step(); step();
    chk("split_next_grant", g_last, 1);

    // Simultaneous push/pop, then done on an empty queue
    req_valid = 4'b0000;
    settle_idle();
    drain();
    req_valid = 4'b0100; step(); req_valid = 4'b0000; step();
    chk("pp_before", outstanding, 4'd1);
    req_valid = 4'b0100; m_rsp_done = 1'b1; step();
    chk("pp_grant", g_last, 2);
    req_valid = 4'b0000; m_rsp_done = 1'b0;
    chk("pp_outstanding", outstanding, 4'd1);
    step();
    drain();
    step();
    m_rsp_done = 1'b1; step(); m_rsp_done = 1'b0;
    chk("err_flag", cpl_err, 1'b1);
    chk("err_no_done", s_rsp_done, 4'b0000);
    chk("err_outstanding", outstanding, 4'd0);

    // Reset during ST_ISSUE with 3 outstanding
    req_valid = 4'b1111;
    collect(3);
    m_req_ready = 1'b0; mux_ready = 1'b0;
    chk("pre_reset_outstanding", outstanding, 4'd3);
    chk("pre_reset_valid", m_req_valid, 1'b1);
    do_reset();
    m_req_ready = 1'b1; mux_ready = 1'b1;
    step();
    chk("post_reset_grant", g_last, 0);

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (g_last == i) begin
          if ($urandom_range(1, 0) == 1) new_req(i);
          else req_valid[i] = 1'b0;
        end else if (!req_valid[i] && $urandom_range(3, 0) == 0) begin
          new_req(i);
          req_valid[i] = 1'b1;
        end
      end
      m_req_ready = ($urandom_range(3, 0) != 0);
      mux_ready   = ($urandom_range(3, 0) != 0);
      m_rsp_done  = ($urandom_range(5, 0) == 0);
      if ($urandom_range(999, 0) == 0) do_reset();
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dma_req_arbiter.md
Name: dma_req_arbiter

Overview:
- Shares one DMA request channel among N_REQ requesters, e.g. vFPGA regions, using round-robin arbitration.
- For each granted request, issues a data-mux descriptor (vfid, beat length, last flag) to the datapath multiplexer.
- Records the granted vfid in an in-order completion queue, so DMA done pulses route back to the originating requester.
- Sits between the per-region request queues and the shared host/card DMA engine.

Parameters:
- N_REQ, 4: number of requesters.
- N_ID_BITS, 2: vfid width; must be at least clog2(N_REQ).
- ADDR_BITS, 64: request address width.
- LEN_BITS, 28: request byte-length width.
- ARB_DATA_BITS, 512: datapath width. BEAT_LOG_BITS = clog2(ARB_DATA_BITS/8).
- N_OUTSTANDING, 8: completion queue depth; must be a power of 2.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- s_req_valid  in  N_REQ  per-requester request valid.
- s_req_ready  out  N_REQ  per-requester accept; one-hot or zero.
- s_req_addr  in  N_REQ*ADDR_BITS  packed addresses; requester i at slice [i*ADDR_BITS +: ADDR_BITS].
- s_req_len  in  N_REQ*LEN_BITS  packed byte lengths.
- s_req_last  in  N_REQ  per-requester last/ctl flag.
- s_rsp_done  out  N_REQ  one-cycle completion pulse to requester.
- m_req_valid  out  1  request to DMA engine.
- m_req_ready  in  1  DMA engine accept.
- m_req_addr  out  ADDR_BITS  granted address.
- m_req_len  out  LEN_BITS  granted byte length.
- m_req_last  out  1  granted last flag.
- m_rsp_done  in  1  in-order completion pulse from DMA engine.
- mux_valid  out  1  mux descriptor valid.
- mux_ready  in  1  mux accept.
- mux_vfid  out  N_ID_BITS  granted requester index.
- mux_len  out  LEN_BITS-BEAT_LOG_BITS  beats minus one.
- mux_ctl  out  1  copy of the last flag.
- outstanding  out  clog2(N_OUTSTANDING)+1  completion queue occupancy.
- cpl_err  out  1  sticky flag: m_rsp_done received while the queue was empty.

Behaviour:
- Reset values (async, aresetn low): every output is 0; FSM in ST_IDLE; RR pointer 0; queue empty.
- FSM states:
  - ST_IDLE: if any s_req_valid and outstanding < N_OUTSTANDING, then:
    - grant = first valid index at or after the RR pointer, modulo N_REQ;
    - s_req_ready[grant] = 1 for that single cycle, combinational in ST_IDLE only;
    - latch addr, len, last and vfid into output registers;
    - push vfid into the completion queue;
    - RR pointer = grant+1, wrapping N_REQ-1 to 0;
    - next state ST_ISSUE.
  - ST_IDLE, otherwise: all s_req_ready are 0.
  - ST_ISSUE: m_req_valid and mux_valid are asserted together on the cycle after the grant.
    - Each deasserts independently on its own handshake: valid & ready at the rising edge.
    - Outputs hold stable while the corresponding valid is high.
    - When both handshakes are done, whether in the same or different cycles, go to ST_IDLE.
    - Back-to-back grants are therefore spaced at least 2 cycles apart.
- Grant-to-m_req_valid latency: 1 cycle.
- mux_len arithmetic:
  - mux_len = ((len + 2^BEAT_LOG_BITS - 1) >> BEAT_LOG_BITS) - 1, computed at LEN_BITS+1 width.
  - len = 0 saturates to mux_len = 0.
- Completion queue:
  - m_rsp_done pops the head vfid; s_rsp_done[head] pulses 1 cycle later (registered).
  - A push and a pop in the same cycle leaves outstanding unchanged and both are legal.
  - When the queue is full, no grant is made; requesters see ready = 0 and are not dropped.
  - m_rsp_done with the queue empty: ignored, cpl_err set to 1 until reset, outstanding stays 0.
- Pointer wrap: queue read/write pointers are clog2(N_OUTSTANDING) bits and wrap naturally.
- Reset mid-operation: an in-flight ST_ISSUE handshake is abandoned and the queue is cleared.
  - The DMA engine and mux must be reset in the same domain.

Optional Feature:
- Macro: DMA_ARB_PRIO_EN.
- With the macro defined:
  - requester 0 has strict priority: whenever s_req_valid[0] is high in ST_IDLE it wins;
  - the RR pointer is left unchanged on a requester-0 grant;
  - requesters 1..N_REQ-1 round-robin among themselves.
- Without the macro: plain round-robin over all N_REQ requesters.
- Ports are identical in both builds.

Test Plan:
- Single request: requester 2, len=200, ARB_DATA_BITS=512, m_req_ready and mux_ready held 1.
  - s_req_ready=0100 for 1 cycle; next cycle m_req_valid=1, m_req_len=200, mux_vfid=2, mux_len=3.
  - m_rsp_done pulse, then s_rsp_done=0100 exactly one cycle later.
- Fairness: all 4 requesters valid continuously, no DMA_ARB_PRIO_EN.
  - Grant order 0,1,2,3,0,1; with DMA_ARB_PRIO_EN the order is 0,0,0...
  - Then drop requester 0: grants rotate 1,2,3,1.
- Split handshakes: mux_ready=0 for 5 cycles while m_req_ready=1.
  - m_req_valid drops after 1 cycle; mux_valid and mux_vfid hold 5 cycles; the next grant only follows the mux handshake.
- Queue full: 8 grants with no m_rsp_done.
  - outstanding=8, all s_req_ready=0.
  - One m_rsp_done gives outstanding=7, then a grant the following cycle.
- Simultaneous push/pop plus error case:
  - grant and m_rsp_done in the same cycle keeps outstanding constant;
  - m_rsp_done on an empty queue sets cpl_err=1 and leaves s_rsp_done=0.
- Reset mid-operation: aresetn low during ST_ISSUE with 3 outstanding.
  - All outputs 0 immediately (async); outstanding=0, cpl_err=0, next grant goes to requester 0.
